// File: rtl/brain_copy_engine_if.sv
// Bus bundle for brain_copy_engine: copy command/status, CPU-side port and RAM-side port.
// The `fill` signal exists only when BRAIN_COPY_ZERO_FILL_EN is defined.
interface brain_copy_engine_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 15
);
    logic                     start;
    logic [ADDRESS_WIDTH-1:0] src_addr;
    logic [ADDRESS_WIDTH-1:0] dst_addr;
    logic [ADDRESS_WIDTH-1:0] len;
    logic                     busy;
    logic                     done;
`ifdef BRAIN_COPY_ZERO_FILL_EN
    logic                     fill;
`endif
    logic                     cpu_wEn;
    logic [ADDRESS_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0]    cpu_dataIn;
    logic [DATA_WIDTH-1:0]    cpu_dataOut;
    logic                     ram_wEn;
    logic [ADDRESS_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]    ram_dataIn;
    logic [DATA_WIDTH-1:0]    ram_dataOut;

    modport slave (
`ifdef BRAIN_COPY_ZERO_FILL_EN
        input  fill,
`endif
        input  start, src_addr, dst_addr, len,
        output busy, done,
        input  cpu_wEn, cpu_addr, cpu_dataIn,
        output cpu_dataOut,
        output ram_wEn, ram_addr, ram_dataIn,
        input  ram_dataOut
    );

    modport master (
`ifdef BRAIN_COPY_ZERO_FILL_EN
        output fill,
`endif
        output start, src_addr, dst_addr, len,
        input  busy, done,
        output cpu_wEn, cpu_addr, cpu_dataIn,
        input  cpu_dataOut,
        input  ram_wEn, ram_addr, ram_dataIn,
        output ram_dataOut
    );
endinterface

// File: rtl/brain_copy_engine.sv
// Block-copy engine owning the single data-RAM port; CPU passes through when idle.
// Optional zero-fill mode enabled by defining BRAIN_COPY_ZERO_FILL_EN.
module brain_copy_engine #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    brain_copy_engine_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    localparam logic [ADDRESS_WIDTH-1:0] ONE = ADDRESS_WIDTH'(1);

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] src_ptr_q, src_ptr_d;
    logic [ADDRESS_WIDTH-1:0] dst_ptr_q, dst_ptr_d;
    logic [ADDRESS_WIDTH-1:0] remaining_q, remaining_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     fill_req;
    logic                     fill_active;

`ifdef BRAIN_COPY_ZERO_FILL_EN
    logic fill_q, fill_d;
    assign fill_req    = bus.fill;
    assign fill_active = fill_q;
`else
    assign fill_req    = 1'b0;
    assign fill_active = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        remaining_d = remaining_q;
`ifdef BRAIN_COPY_ZERO_FILL_EN
        fill_d      = fill_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    src_ptr_d   = bus.src_addr;
                    dst_ptr_d   = bus.dst_addr;
                    remaining_d = bus.len;
`ifdef BRAIN_COPY_ZERO_FILL_EN
                    fill_d      = bus.fill;
`endif
                    if (bus.len == '0)  state_d = S_DONE;
                    else if (fill_req)  state_d = S_WRITE;
                    else                state_d = S_READ;
                end
            end
            S_READ:  state_d = S_WRITE;
            S_WRITE: begin
                // Pointers wrap naturally at the address width.
                src_ptr_d   = src_ptr_q + ONE;
                dst_ptr_d   = dst_ptr_q + ONE;
                remaining_d = remaining_q - ONE;
                if (remaining_q == ONE) state_d = S_DONE;
                else if (fill_active)   state_d = S_WRITE;
                else                    state_d = S_READ;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_READ) || (state_d == S_WRITE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef BRAIN_COPY_ZERO_FILL_EN
            fill_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef BRAIN_COPY_ZERO_FILL_EN
            fill_q      <= fill_d;
`endif
        end
    end

    // RAM port mux: CPU owns it outside READ/WRITE; its writes are dropped while copying.
    always_comb begin
        bus.ram_wEn    = bus.cpu_wEn;
        bus.ram_addr   = bus.cpu_addr;
        bus.ram_dataIn = bus.cpu_dataIn;
        case (state_q)
            S_READ: begin
                bus.ram_wEn    = 1'b0;
                bus.ram_addr   = src_ptr_q;
                bus.ram_dataIn = '0;
            end
            S_WRITE: begin
                bus.ram_wEn    = 1'b1;
                bus.ram_addr   = dst_ptr_q;
                bus.ram_dataIn = fill_active ? '0 : bus.ram_dataOut;
            end
            default: ;
        endcase
    end

    assign bus.cpu_dataOut = bus.ram_dataOut;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_brain_copy_engine.sv
// Directed bench for brain_copy_engine: vector table of copies plus reset/ignore/fill sequences.
module tb_brain_copy_engine;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   wr_cnt;

    brain_copy_engine_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(15)) bus ();

    brain_copy_engine #(.DATA_WIDTH(32), .ADDRESS_WIDTH(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Single-port RAM model: one-cycle read latency, output held during writes.
    logic [31:0] mem [0:32767];
    always @(posedge clk) begin
        if (bus.ram_wEn) begin
            mem[bus.ram_addr] <= bus.ram_dataIn;
            wr_cnt            <= wr_cnt + 1;
        end else begin
            bus.ram_dataOut   <= mem[bus.ram_addr];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [14:0]      src;
        logic [14:0]      dst;
        logic [14:0]      len;
        logic             chk_src;
        logic [0:3][31:0] pre;
        logic [0:3][31:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic cpu_write(input logic [14:0] a, input logic [31:0] d);
        bus.cpu_addr   = a;
        bus.cpu_dataIn = d;
        bus.cpu_wEn    = 1'b1;
        tick();
        bus.cpu_wEn    = 1'b0;
    endtask

    task automatic cpu_read(input logic [14:0] a, output logic [31:0] d);
        bus.cpu_addr = a;
        bus.cpu_wEn  = 1'b0;
        tick();
        d = bus.cpu_dataOut;
    endtask

    task automatic set_cmd(input logic s, input logic [14:0] sa, input logic [14:0] da,
                           input logic [14:0] l);
        bus.start    = s;
        bus.src_addr = sa;
        bus.dst_addr = da;
        bus.len      = l;
    endtask

    task automatic run_vec(input int idx);
        vec_t        v;
        int          n;
        int          w0;
        logic [31:0] rd;
        logic [14:0] ea;
        v = vecs[idx];
        n = int'(v.len);
        for (int i = 0; i < 4; i++) cpu_write(v.dst + 15'(i), 32'h5E00_0000 | 32'(i));
        for (int i = 0; i < 4; i++) cpu_write(v.src + 15'(i), v.pre[i]);
        w0 = wr_cnt;
        set_cmd(1'b1, v.src, v.dst, v.len);
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 2 * n + 1; k++) begin
            check($sformatf("v%0d busy c%0d", idx, k), {31'd0, bus.busy}, {31'd0, k <= 2 * n});
            check($sformatf("v%0d done c%0d", idx, k), {31'd0, bus.done}, {31'd0, k == 2 * n + 1});
            if (k <= 2 * n) begin
                if (k % 2 == 1) ea = v.src + 15'((k - 1) / 2);
                else            ea = v.dst + 15'((k / 2) - 1);
                check($sformatf("v%0d addr c%0d", idx, k), {17'd0, bus.ram_addr}, {17'd0, ea});
                check($sformatf("v%0d wen c%0d", idx, k), {31'd0, bus.ram_wEn}, {31'd0, k % 2 == 0});
            end else begin
                // start raised in DONE must be ignored
                set_cmd(1'b1, 15'h7000, 15'h7100, 15'd1);
            end
            tick();
        end
        bus.start = 1'b0;
        check($sformatf("v%0d busy after done", idx), {31'd0, bus.busy}, 32'd0);
        check($sformatf("v%0d done after done", idx), {31'd0, bus.done}, 32'd0);
        check($sformatf("v%0d write count", idx), 32'(wr_cnt - w0), 32'(n));
        for (int i = 0; i < 4; i++) begin
            cpu_read(v.dst + 15'(i), rd);
            check($sformatf("v%0d dst[%0d]", idx, i), rd, v.exp[i]);
        end
        if (v.chk_src) begin
            for (int i = 0; i < 4; i++) begin
                cpu_read(v.src + 15'(i), rd);
                check($sformatf("v%0d src[%0d]", idx, i), rd, v.pre[i]);
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        total = 0;
        bad   = 0;
        wr_cnt = 0;
        reset = 1'b1;
        bus.cpu_wEn = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_dataIn = '0;
        set_cmd(1'b0, '0, '0, '0);
`ifdef BRAIN_COPY_ZERO_FILL_EN
        bus.fill = 1'b0;
`endif
        vecs[0] = '{src: 15'h0010, dst: 15'h0100, len: 15'd4, chk_src: 1'b1,
                    pre: {32'hAAAA_0000, 32'hBBBB_0001, 32'hCCCC_0002, 32'hDDDD_0003},
                    exp: {32'hAAAA_0000, 32'hBBBB_0001, 32'hCCCC_0002, 32'hDDDD_0003}};
        vecs[1] = '{src: 15'h0030, dst: 15'h0130, len: 15'd0, chk_src: 1'b1,
                    pre: {32'h1234_0000, 32'h1234_0001, 32'h1234_0002, 32'h1234_0003},
                    exp: {32'h5E00_0000, 32'h5E00_0001, 32'h5E00_0002, 32'h5E00_0003}};
        vecs[2] = '{src: 15'h0020, dst: 15'h0021, len: 15'd3, chk_src: 1'b0,
                    pre: {32'd1, 32'd2, 32'd3, 32'd4},
                    exp: {32'd1, 32'd1, 32'd1, 32'h5E00_0003}};
        vecs[3] = '{src: 15'h7FFE, dst: 15'h0200, len: 15'd4, chk_src: 1'b1,
                    pre: {32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044},
                    exp: {32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044}};
        vecs[4] = '{src: 15'h0040, dst: 15'h0140, len: 15'd1, chk_src: 1'b1,
                    pre: {32'h0000_0077, 32'h0000_0078, 32'h0000_0079, 32'h0000_007A},
                    exp: {32'h0000_0077, 32'h5E00_0001, 32'h5E00_0002, 32'h5E00_0003}};

        tick();
        tick();
        reset = 1'b0;
        bus.cpu_addr = 15'h0123;
        bus.cpu_dataIn = 32'h0000_0055;
        #1;
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("pass addr", {17'd0, bus.ram_addr}, 32'h0000_0123);
        check("pass data", bus.ram_dataIn, 32'h0000_0055);
        check("pass wen", {31'd0, bus.ram_wEn}, 32'd0);

        for (int i = 0; i < 5; i++) run_vec(i);

        // Reset mid-copy, dropped CPU write, ignored second start.
        for (int i = 0; i < 4; i++) cpu_write(15'h0050 + 15'(i), 32'hA1 + 32'(i));
        for (int i = 0; i < 4; i++) cpu_write(15'h0150 + 15'(i), 32'h5E00_0000 | 32'(i));
        cpu_write(15'h0400, 32'h0000_1111);
        cpu_write(15'h0500, 32'h0000_3333);
        cpu_write(15'h0600, 32'h0000_2222);
        set_cmd(1'b1, 15'h0050, 15'h0150, 15'd4);
        tick();
        set_cmd(1'b1, 15'h0500, 15'h0600, 15'd1);
        bus.cpu_addr = 15'h0400;
        bus.cpu_dataIn = 32'h0000_DEAD;
        bus.cpu_wEn = 1'b1;
        #1;
        check("rst busy c1", {31'd0, bus.busy}, 32'd1);
        check("rst cpu wen dropped c1", {31'd0, bus.ram_wEn}, 32'd0);
        tick();
        check("rst addr c2", {17'd0, bus.ram_addr}, 32'h0000_0150);
        tick();
        bus.cpu_wEn = 1'b0;
        bus.start = 1'b0;
        #1;
        check("rst addr c3", {17'd0, bus.ram_addr}, 32'h0000_0051);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rst busy after", {31'd0, bus.busy}, 32'd0);
        check("rst done after", {31'd0, bus.done}, 32'd0);
        bus.cpu_addr = 15'h0700;
        bus.cpu_dataIn = 32'h0000_BEEF;
        bus.cpu_wEn = 1'b1;
        #1;
        check("rst idle cpu wen", {31'd0, bus.ram_wEn}, 32'd1);
        tick();
        bus.cpu_wEn = 1'b0;
        cpu_read(15'h0150, rd); check("rst dst0", rd, 32'h0000_00A1);
        cpu_read(15'h0151, rd); check("rst dst1", rd, 32'h0000_00A2);
        cpu_read(15'h0152, rd); check("rst dst2", rd, 32'h5E00_0002);
        cpu_read(15'h0153, rd); check("rst dst3", rd, 32'h5E00_0003);
        cpu_read(15'h0400, rd); check("busy cpu write dropped", rd, 32'h0000_1111);
        cpu_read(15'h0600, rd); check("second start ignored", rd, 32'h0000_2222);
        cpu_read(15'h0700, rd); check("idle cpu write lands", rd, 32'h0000_BEEF);

`ifdef BRAIN_COPY_ZERO_FILL_EN
        for (int i = 0; i < 4; i++) cpu_write(15'h0300 + 15'(i), 32'hFFFF_0000 | 32'(i));
        set_cmd(1'b1, 15'h0055, 15'h0300, 15'd3);
        bus.fill = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.fill = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("fill busy c%0d", k), {31'd0, bus.busy}, {31'd0, k <= 3});
            check($sformatf("fill done c%0d", k), {31'd0, bus.done}, {31'd0, k == 4});
            if (k <= 3) begin
                check($sformatf("fill addr c%0d", k), {17'd0, bus.ram_addr}, 32'h300 + 32'(k - 1));
                check($sformatf("fill data c%0d", k), bus.ram_dataIn, 32'd0);
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            cpu_read(15'h0300 + 15'(i), rd);
            check($sformatf("fill mem[%0d]", i), rd, (i < 3) ? 32'd0 : 32'hFFFF_0003);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
